// File: rtl/fpu_op_scheduler.sv
// fpu_op_scheduler
//   Single-issue sequencer in front of the FPU add/mul/div/sub units. It accepts one
//   tagged request (valid/ready), decodes the opcode, starts exactly one unit, waits
//   for that unit's done, and returns the result on a valid/ready response port.
//   The units see operands only while a request is issued. At all other times the
//   operand buses are zero.
//
//   Optional feature: define FPU_SCHED_TIMEOUT_EN to add a WAIT-cycle limit of TIMEOUT
//   cycles. When the limit expires, the scheduler returns an error response (qNaN,
//   rsp_err=1). Without the macro, WAIT waits indefinitely.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   req_valid/ready     request handshake; ready only in IDLE
//   req_op              0=add 1=mul 2=div 3=sub; 4..15 illegal
//   req_a, req_b        IEEE-754 single operands
//   req_tag             opaque tag echoed on the response
//   unit_start          one-hot start pulse, bit index = opcode
//   unit_a, unit_b      latched operands to the units
//   unit_done           per-unit done pulse, bit index = opcode
//   unit_result         packed unit results, slice k = unit k
//   rsp_valid/ready     response handshake
//   rsp_result          result, 32'h7FC0_0000 on error
//   rsp_tag, rsp_err    echoed tag and error flag (illegal opcode or timeout)
//   busy                scheduler not in IDLE
module fpu_op_scheduler #(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [3:0]       unit_start,
  output logic [31:0]      unit_a,
  output logic [31:0]      unit_b,
  input  logic [3:0]       unit_done,
  input  logic [127:0]     unit_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_e           state_q;
  logic [1:0]       op_q;
  logic [3:0]       unit_start_q;
  logic [31:0]      unit_a_q;
  logic [31:0]      unit_b_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_result_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_err_q;

  logic             op_done_d;
  logic [31:0]      op_result_d;

  // Only the issued unit's done bit and result slice are ever looked at.
  always_comb begin
    op_done_d   = unit_done[op_q];
    op_result_d = unit_result[{op_q, 5'd0} +: 32];
  end

`ifdef FPU_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] wait_cnt_q;
`else
  // TIMEOUT has no effect without the timeout feature.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT >= 2);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      unit_start_q <= '0;
      unit_a_q     <= '0;
      unit_b_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
`ifdef FPU_SCHED_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          // req_ready is high throughout IDLE, so req_valid alone means a handshake.
          if (req_valid) begin
            rsp_tag_q <= req_tag;
            if (req_op < 4'd4) begin
              op_q         <= req_op[1:0];
              unit_a_q     <= req_a;
              unit_b_q     <= req_b;
              unit_start_q <= 4'b0001 << req_op[1:0];
              state_q      <= S_ISSUE;
            end else begin
              rsp_result_q <= QNAN;
              rsp_err_q    <= 1'b1;
              rsp_valid_q  <= 1'b1;
              state_q      <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          unit_start_q <= '0;
          state_q      <= S_WAIT;
`ifdef FPU_SCHED_TIMEOUT_EN
          wait_cnt_q   <= '0;
`endif
        end
        S_WAIT: begin
          // A done arriving in the limit cycle takes priority over the timeout.
          if (op_done_d) begin
            rsp_result_q <= op_result_d;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end
`ifdef FPU_SCHED_TIMEOUT_EN
          else if (wait_cnt_q == CNT_LAST) begin
            rsp_result_q <= QNAN;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            unit_a_q    <= '0;
            unit_b_q    <= '0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign unit_start = unit_start_q;
  assign unit_a     = unit_a_q;
  assign unit_b     = unit_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_fpu_op_scheduler.sv
module tb_fpu_op_scheduler;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready;
  logic [3:0]       req_op;
  logic [31:0]      req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic [3:0]       unit_start;
  logic [31:0]      unit_a, unit_b;
  logic [3:0]       unit_done;
  logic [127:0]     unit_result;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err, busy;

  always #5 clk = ~clk;

  fpu_op_scheduler #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_result(unit_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    logic [3:0]       op;
    logic [31:0]      a, b, res;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               lat;
    int               acc;
  } exp_t;

  exp_t exp_q[$];
  int   delay_q[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Stand-in unit behaviour: the mul case from the datasheet example, otherwise a hash.
  function automatic logic [31:0] rfn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 2'd1 && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return (a ^ {b[15:0], b[31:16]}) + 32'(op) * 32'h0101_0101;
  endfunction

  // Unit model: on a start pulse, wait the queued delay, then pulse done on that unit
  // with a result computed from the operands the scheduler is presenting.
  logic       pend = 1'b0;
  logic [1:0] pend_op = '0;
  int         pend_cnt = 0;
  bit         freeze = 0, stray_en = 0;
  logic [3:0] force_bits = '0;

  initial begin
    logic [3:0] ud;
    unit_done   = '0;
    unit_result = '0;
    forever begin
      @(posedge clk); #1;
      ud = '0;
      for (int k = 0; k < 4; k++) unit_result[32*k +: 32] = $urandom;
      if (!rst_n) pend = 1'b0;
      else if (unit_start != 4'b0000) begin
        pend     = 1'b1;
        pend_op  = unit_start[1] ? 2'd1 : unit_start[2] ? 2'd2 : unit_start[3] ? 2'd3 : 2'd0;
        pend_cnt = (delay_q.size() > 0) ? delay_q.pop_front() : 1;
      end else if (pend && !freeze) begin
        pend_cnt--;
        if (pend_cnt <= 0) begin
          ud[pend_op] = 1'b1;
          unit_result[32*pend_op +: 32] = rfn(pend_op, unit_a, unit_b);
          pend = 1'b0;
        end
      end
      if (stray_en && $urandom_range(0, 3) == 0)
        ud = ud | (4'($urandom) & ~(pend ? (4'b0001 << pend_op) : 4'b0000));
      unit_done = ud | force_bits;
    end
  end

  // Response consumer: 0 = random, 1 = held low, 2 = held high.
  int rdy_mode = 0;
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = (rdy_mode == 1) ? 1'b0 : (rdy_mode == 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: checks every response against the scoreboard and watches protocol rules.
  logic             prev_valid = 1'b0, prev_hold = 1'b0;
  logic [3:0]       prev_start = '0, exp_start;
  logic [31:0]      h_res;
  logic [TAG_W-1:0] h_tag;
  logic             h_err;
  exp_t             mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0; prev_hold = 1'b0; prev_start = '0;
        continue;
      end
      chk("ready_vs_busy", 64'(req_ready), 64'(!busy));
      if (!busy) begin
        chk("idle_operands", {unit_a, unit_b}, 64'd0);
        chk("idle_quiet", {rsp_valid, unit_start}, 64'd0);
      end
      if (unit_start != 4'b0000) begin
        if (exp_q.size() == 0) chk("start_unexpected", 64'(unit_start), 64'd0);
        else begin
          exp_start = 4'b0001 << exp_q[0].op;
          if (exp_q[0].op > 4'd3) exp_start = 4'b0000;
          chk("start_onehot", 64'(unit_start), 64'(exp_start));
          chk("start_single", 64'(prev_start), 64'd0);
          chk("start_operands", {unit_a, unit_b}, {exp_q[0].a, exp_q[0].b});
        end
      end
      prev_start = unit_start;
      if (prev_hold)
        chk("rsp_stable", 64'({rsp_valid, rsp_result, rsp_tag, rsp_err}), 64'({1'b1, h_res, h_tag, h_err}));
      if (rsp_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rsp_unexpected: got rsp_valid=1, expected no response (cycle %0d)", cyc);
        end else chk("rsp_latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
      end
      if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("rsp_result", 64'(rsp_result), 64'(mon_e.res));
        chk("rsp_tag", 64'(rsp_tag), 64'(mon_e.tag));
        chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
      end
      prev_hold  = rsp_valid && !rsp_ready;
      h_res      = rsp_result;
      h_tag      = rsp_tag;
      h_err      = rsp_err;
      prev_valid = rsp_valid;
    end
  end

  // Present one request; on acceptance push the expected response.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input int d, input bit to);
    exp_t e;
    bit   ok = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    for (int i = 0; i < 400; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 for 400 cycles, expected acceptance");
      req_valid = 1'b0;
      return;
    end
    e.op  = op; e.a = a; e.b = b; e.tag = tag;
    e.err = (op > 4'd3) || to;
    e.res = e.err ? QNAN : rfn(op[1:0], a, b);
    e.lat = (op > 4'd3) ? 1 : to ? int'(TIMEOUT) + 2 : d + 2;
    e.acc = cyc;
    exp_q.push_back(e);
    if (op <= 4'd3) delay_q.push_back(d);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'($urandom); req_a = $urandom; req_b = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 64'({req_ready, busy, rsp_valid, rsp_err, unit_start}), 64'(8'b1000_0000));
    chk("reset_operands", {unit_a, unit_b}, 64'd0);
    chk("reset_rsp", 64'({rsp_result, rsp_tag}), 64'd0);
    rst_n = 1'b1;

    // Mul example, done two cycles after start.
    issue(4'd1, 32'h4000_0000, 32'h4040_0000, 4'h3, 2, 0);
    drain();
    // Illegal opcode straight to response.
    issue(4'd7, $urandom, $urandom, 4'd5, 0, 0);
    drain();

    // Backpressure on an add.
    rdy_mode = 1;
    issue(4'd0, $urandom, $urandom, 4'hA, 1, 0);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_rsp_seen", 64'(rsp_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold", 64'({busy, req_ready, rsp_valid}), 64'(3'b101));
    end
    rdy_mode = 2;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release", 64'({busy, req_ready, rsp_valid}), 64'(3'b010));
    rdy_mode = 0;
    drain();

    // Div with a stray add-done while waiting.
    issue(4'd2, $urandom, $urandom, 4'h6, 6, 0);
    @(negedge clk); force_bits = 4'b0001;
    @(negedge clk); force_bits = 4'b0000;
    drain();

    // Randomized traffic with stray done pulses and random consumer backpressure.
    stray_en = 1;
    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      issue(op, $urandom, $urandom, 4'($urandom), $urandom_range(1, 6), 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain();
    stray_en = 0;

    // Reset in WAIT, then a late done from the abandoned unit.
    freeze = 1;
    issue(4'd2, $urandom, $urandom, 4'h9, 1, 0);
    repeat (4) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    exp_q.delete(); delay_q.delete();
    #1;
    chk("rst_mid_ctrl", 64'({req_ready, busy, rsp_valid, rsp_err, unit_start}), 64'(8'b1000_0000));
    chk("rst_mid_data", {unit_a, unit_b}, 64'd0);
    chk("rst_mid_rsp", 64'({rsp_result, rsp_tag}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    freeze = 0;
    force_bits = 4'b0100;
    @(negedge clk); force_bits = 4'b0000;
    repeat (10) @(negedge clk);
    chk("rst_late_done", 64'({busy, rsp_valid}), 64'd0);

`ifdef FPU_SCHED_TIMEOUT_EN
    // Div that never completes.
    freeze = 1;
    issue(4'd2, $urandom, $urandom, 4'hC, 1, 1);
    drain();
    freeze = 0;
    pend = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
